target_generator: RTL and testbench

Producer side of the REACHED event that the score counter consumes.
- Holds the current target (food) coordinate on the VGA game grid.
- Compares it against the snake head position each time the head moves.
- On a hit, emits a one-cycle REACHED pulse, then relocates the target to a pseudo-random in-range cell using free-running LFSRs.
- Freezes once WIN is returned from the score counter.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/lfsr_gen.sv | 24 ++
 rtl/target_generator.sv | 123 ++++++++++++
 tb/tb_target_generator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and grid constants for the snake game datapath.
package snake_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    RELOCATE = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam int unsigned X_WIDTH = 8;
  localparam int unsigned Y_WIDTH = 7;
  localparam int unsigned X_MAX   = 159;
  localparam int unsigned Y_MAX   = 119;

  // Fibonacci tap masks: x^8+x^6+x^5+x^4+1 and x^7+x^6+1
  localparam logic [7:0] TAPS_8 = 8'hB8;
  localparam logic [6:0] TAPS_7 = 7'h60;

  // Maximal-length tap mask for the supported widths; zero for anything else
  function automatic logic [31:0] taps_for(input int unsigned width);
    logic [31:0] mask;
    mask = 32'd0;
    case (width)
      7:       mask = 32'(TAPS_7);
      8:       mask = 32'(TAPS_8);
      default: mask = 32'd0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR, shifting left every cycle; a nonzero seed never reaches zero.
module lfsr_gen #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = '0,
  parameter logic [WIDTH-1:0] SEED = '1
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q <= SEED;
    end else begin
      q <= {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

  assign OUT = q;

endmodule

// File: rtl/target_generator.sv
// Holds the food target, pulses REACHED on a head hit, then relocates the target
// to a pseudo-random in-range cell; freezes once WIN is asserted.
module target_generator
  import snake_pkg::*;
#(
  parameter int unsigned X_WIDTH = snake_pkg::X_WIDTH,
  parameter int unsigned Y_WIDTH = snake_pkg::Y_WIDTH,
  parameter int unsigned X_MAX   = snake_pkg::X_MAX,
  parameter int unsigned Y_MAX   = snake_pkg::Y_MAX,
  parameter int unsigned X_INIT  = 80,
  parameter int unsigned Y_INIT  = 60,
  parameter logic [X_WIDTH-1:0] X_SEED = X_WIDTH'(8'hA5),
  parameter logic [Y_WIDTH-1:0] Y_SEED = Y_WIDTH'(7'h2B)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [X_WIDTH-1:0] HEAD_X,
  input  logic [Y_WIDTH-1:0] HEAD_Y,
  input  logic               HEAD_VALID,
  input  logic               WIN,
  output logic [X_WIDTH-1:0] TARGET_X,
  output logic [Y_WIDTH-1:0] TARGET_Y,
  output logic               TARGET_VALID,
  output logic               REACHED
);

  localparam logic [X_WIDTH-1:0] X_MAX_W  = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_MAX_W  = Y_WIDTH'(Y_MAX);
  localparam logic [X_WIDTH-1:0] X_INIT_W = X_WIDTH'(X_INIT);
  localparam logic [Y_WIDTH-1:0] Y_INIT_W = Y_WIDTH'(Y_INIT);
  localparam logic [X_WIDTH-1:0] X_TAPS   = X_WIDTH'(taps_for(X_WIDTH));
  localparam logic [Y_WIDTH-1:0] Y_TAPS   = Y_WIDTH'(taps_for(Y_WIDTH));

  state_t             state, state_nx;
  logic [X_WIDTH-1:0] target_x_nx;
  logic [Y_WIDTH-1:0] target_y_nx;
  logic               target_valid_nx;
  logic               reached_nx;
  logic [X_WIDTH-1:0] lfsr_x;
  logic [Y_WIDTH-1:0] lfsr_y;
  logic               hit_c;
  logic               accept_c;

  lfsr_gen #(
    .WIDTH (X_WIDTH),
    .TAPS  (X_TAPS),
    .SEED  (X_SEED)
  ) u_lfsr_x (
    .CLK   (CLK),
    .RESET (RESET),
    .OUT   (lfsr_x)
  );

  lfsr_gen #(
    .WIDTH (Y_WIDTH),
    .TAPS  (Y_TAPS),
    .SEED  (Y_SEED)
  ) u_lfsr_y (
    .CLK   (CLK),
    .RESET (RESET),
    .OUT   (lfsr_y)
  );

  assign hit_c    = HEAD_VALID && (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);
  assign accept_c = (lfsr_x <= X_MAX_W) && (lfsr_y <= Y_MAX_W) &&
                    !((lfsr_x == HEAD_X) && (lfsr_y == HEAD_Y));

  // Next-state and next-output logic; WIN takes priority over any hit
  always_comb begin
    state_nx        = state;
    target_x_nx     = TARGET_X;
    target_y_nx     = TARGET_Y;
    target_valid_nx = TARGET_VALID;
    reached_nx      = 1'b0;

    if (WIN) begin
      state_nx        = DONE;
      target_valid_nx = 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (hit_c) begin
            state_nx        = RELOCATE;
            reached_nx      = 1'b1;
            target_valid_nx = 1'b0;
          end
        end
        RELOCATE: begin
          if (accept_c) begin
            state_nx        = ARMED;
            target_x_nx     = lfsr_x;
            target_y_nx     = lfsr_y;
            target_valid_nx = 1'b1;
          end
        end
        DONE: begin
          target_valid_nx = 1'b0;
        end
        default: begin
          state_nx = ARMED;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ARMED;
      TARGET_X     <= X_INIT_W;
      TARGET_Y     <= Y_INIT_W;
      TARGET_VALID <= 1'b1;
      REACHED      <= 1'b0;
    end else begin
      state        <= state_nx;
      TARGET_X     <= target_x_nx;
      TARGET_Y     <= target_y_nx;
      TARGET_VALID <= target_valid_nx;
      REACHED      <= reached_nx;
    end
  end

endmodule

// File: tb/tb_target_generator.sv
// Directed bench for target_generator with an independent LFSR model predicting each relocation.
module tb_target_generator;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       HEAD_VALID = 1'b0;
  logic       WIN = 1'b0;
  logic [7:0] HEAD_X = 8'd0;
  logic [6:0] HEAD_Y = 7'd0;
  logic [7:0] TARGET_X;
  logic [6:0] TARGET_Y;
  logic       TARGET_VALID;
  logic       REACHED;

  int tests = 0;
  int failed = 0;
  int pulses = 0;
  int doubles = 0;
  logic prev_reached = 1'b0;

  logic [7:0] mx;
  logic [6:0] my;
  logic [7:0] ex;
  logic [6:0] ey;

  always #5 CLK = ~CLK;

  target_generator dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .HEAD_X       (HEAD_X),
    .HEAD_Y       (HEAD_Y),
    .HEAD_VALID   (HEAD_VALID),
    .WIN          (WIN),
    .TARGET_X     (TARGET_X),
    .TARGET_Y     (TARGET_Y),
    .TARGET_VALID (TARGET_VALID),
    .REACHED      (REACHED)
  );

  function automatic logic [7:0] nx_x(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [6:0] nx_y(input logic [6:0] q);
    return {q[5:0], q[6] ^ q[5]};
  endfunction

  // Reference LFSRs, kept in lockstep with the design's generators
  always @(posedge CLK) begin
    if (RESET) begin
      mx <= 8'hA5;
      my <= 7'h2B;
    end else begin
      mx <= nx_x(mx);
      my <= nx_y(my);
    end
  end

  always @(negedge CLK) begin
    if (REACHED === 1'b1) begin
      pulses++;
      if (prev_reached) doubles++;
    end
    prev_reached = (REACHED === 1'b1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First acceptable candidate starting from the model's current LFSR values
  task automatic predict(input logic [7:0] hx, input logic [6:0] hy,
                         output logic [7:0] tx, output logic [6:0] ty, output int k);
    logic [7:0] cx;
    logic [6:0] cy;
    cx = mx;
    cy = my;
    k  = 0;
    while (!((cx <= 8'd159) && (cy <= 7'd119) && !((cx == hx) && (cy == hy)))) begin
      cx = nx_x(cx);
      cy = nx_y(cy);
      k++;
    end
    tx = cx;
    ty = cy;
  endtask

  // Hit the expected target and follow the relocation to its new, predicted cell
  task automatic hit_and_relocate();
    logic [7:0] px;
    logic [6:0] py;
    int k;
    int lat;
    HEAD_X     = ex;
    HEAD_Y     = ey;
    HEAD_VALID = 1'b1;
    step();
    HEAD_VALID = 1'b0;
    chk("hit_reached", 32'(REACHED), 32'd1);
    chk("hit_valid_low", 32'(TARGET_VALID), 32'd0);
    predict(ex, ey, px, py, k);
    step();
    lat = 1;
    chk("reached_one_cycle", 32'(REACHED), 32'd0);
    while ((TARGET_VALID !== 1'b1) && (lat < 64)) begin
      step();
      lat++;
    end
    chk("reloc_valid", 32'(TARGET_VALID), 32'd1);
    chk("reloc_latency", 32'(lat), 32'(k + 1));
    chk("reloc_x", 32'(TARGET_X), 32'(px));
    chk("reloc_y", 32'(TARGET_Y), 32'(py));
    chk("x_range", 32'(TARGET_X <= 8'd159), 32'd1);
    chk("y_range", 32'(TARGET_Y <= 7'd119), 32'd1);
    chk("differs_head", 32'((TARGET_X == ex) && (TARGET_Y == ey)), 32'd0);
    ex = px;
    ey = py;
  endtask

  initial begin
    // Reset for two cycles
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    chk("rst_x", 32'(TARGET_X), 32'd80);
    chk("rst_y", 32'(TARGET_Y), 32'd60);
    chk("rst_valid", 32'(TARGET_VALID), 32'd1);
    chk("rst_reached", 32'(REACHED), 32'd0);
    ex = 8'd80;
    ey = 7'd60;

    // Matching head without the strobe
    HEAD_X = 8'd80;
    HEAD_Y = 7'd60;
    HEAD_VALID = 1'b0;
    step();
    step();
    chk("nostrobe_reached", 32'(REACHED), 32'd0);
    chk("nostrobe_valid", 32'(TARGET_VALID), 32'd1);

    // Strobed miss, one column off
    HEAD_X = 8'd81;
    HEAD_VALID = 1'b1;
    step();
    HEAD_VALID = 1'b0;
    chk("miss_reached", 32'(REACHED), 32'd0);
    step();
    chk("miss_x", 32'(TARGET_X), 32'd80);
    chk("miss_y", 32'(TARGET_Y), 32'd60);
    chk("miss_valid", 32'(TARGET_VALID), 32'd1);

    // Basic hit plus 1000 forced hits
    hit_and_relocate();
    for (int i = 0; i < 1000; i++) hit_and_relocate();

    // WIN raised together with a valid hit
    HEAD_X = ex;
    HEAD_Y = ey;
    HEAD_VALID = 1'b1;
    WIN = 1'b1;
    step();
    HEAD_VALID = 1'b0;
    chk("win_reached", 32'(REACHED), 32'd0);
    chk("win_valid", 32'(TARGET_VALID), 32'd0);
    chk("win_x", 32'(TARGET_X), 32'(ex));
    chk("win_y", 32'(TARGET_Y), 32'(ey));
    WIN = 1'b0;
    step();
    HEAD_VALID = 1'b1;
    step();
    HEAD_VALID = 1'b0;
    chk("done_reached", 32'(REACHED), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("done_valid", 32'(TARGET_VALID), 32'd0);
    chk("done_x", 32'(TARGET_X), 32'(ex));
    chk("done_y", 32'(TARGET_Y), 32'(ey));

    // Reset out of DONE
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    chk("rst2_x", 32'(TARGET_X), 32'd80);
    chk("rst2_y", 32'(TARGET_Y), 32'd60);
    chk("rst2_valid", 32'(TARGET_VALID), 32'd1);

    // Reset during RELOCATE, right after the pulse
    HEAD_X = 8'd80;
    HEAD_Y = 7'd60;
    HEAD_VALID = 1'b1;
    step();
    HEAD_VALID = 1'b0;
    chk("mid_reached", 32'(REACHED), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_x", 32'(TARGET_X), 32'd80);
    chk("mid_rst_y", 32'(TARGET_Y), 32'd60);
    chk("mid_rst_valid", 32'(TARGET_VALID), 32'd1);
    chk("mid_rst_reached", 32'(REACHED), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("mid_quiet_reached", 32'(REACHED), 32'd0);
    chk("mid_quiet_valid", 32'(TARGET_VALID), 32'd1);

    // Back in ARMED: a fresh hit relocates from the reseeded LFSRs
    ex = 8'd80;
    ey = 7'd60;
    hit_and_relocate();

    chk("pulse_count", 32'(pulses), 32'd1003);
    chk("no_double_pulse", 32'(doubles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
